// File: rtl/calc_req_driver.sv
// rtl/calc_req_driver.sv - drives one calc DUT request port from a command stream,
// allocating request tags and retiring them on response or timeout.
module calc_req_driver #(
    parameter int DATA_W   = 32,
    parameter int NUM_TAGS = 4,
    parameter int TIMEOUT  = 64
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        cmd_valid,
    output logic                        cmd_ready,
    input  logic [3:0]                  cmd_op,
    input  logic [DATA_W-1:0]           cmd_op1,
    input  logic [DATA_W-1:0]           cmd_op2,
    output logic [3:0]                  req_cmd,
    output logic [DATA_W-1:0]           req_data,
    output logic [$clog2(NUM_TAGS)-1:0] req_tag,
    input  logic [1:0]                  out_resp,
    input  logic [DATA_W-1:0]           out_data,
    input  logic [$clog2(NUM_TAGS)-1:0] out_tag,
    output logic                        rsp_valid,
    output logic [1:0]                  rsp_resp,
    output logic [DATA_W-1:0]           rsp_data,
    output logic [$clog2(NUM_TAGS)-1:0] rsp_tag,
    output logic                        spurious_err,
    output logic                        timeout_err,
    output logic [$clog2(NUM_TAGS)-1:0] err_tag,
    output logic [NUM_TAGS-1:0]         busy_mask
);

    localparam int TAG_W = $clog2(NUM_TAGS);
    localparam int AGE_W = $clog2(TIMEOUT) + 1;
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT - 1);
    localparam logic [AGE_W-1:0] AGE_ONE = AGE_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_OP1,
        ST_OP2
    } state_t;

    state_t              state_q, state_d;
    logic [3:0]          req_cmd_q, req_cmd_d;
    logic [DATA_W-1:0]   req_data_q, req_data_d;
    logic [TAG_W-1:0]    req_tag_q, req_tag_d;
    logic [DATA_W-1:0]   op2_q, op2_d;
    logic [NUM_TAGS-1:0] busy_q, busy_d;
    logic [AGE_W-1:0]    age_q [NUM_TAGS];
    logic [AGE_W-1:0]    age_d [NUM_TAGS];
    logic                rsp_valid_q, rsp_valid_d;
    logic [1:0]          rsp_resp_q, rsp_resp_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic [TAG_W-1:0]    rsp_tag_q, rsp_tag_d;
    logic                spurious_q, spurious_d;
    logic                timeout_q, timeout_d;
    logic [TAG_W-1:0]    err_tag_q, err_tag_d;

    logic                free_any;
    logic [TAG_W-1:0]    free_tag;
    logic                accept;
    logic                retire_hit;
    logic                spurious_hit;
    logic                to_hit;
    logic [TAG_W-1:0]    to_tag;

    always_comb begin
        free_any = ~&busy_q;
        free_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (!busy_q[i]) free_tag = TAG_W'(i);
        end
        cmd_ready = (state_q == ST_IDLE) && free_any && (cmd_op != 4'd0) && !reset;
        accept    = cmd_valid && cmd_ready;

        retire_hit   = (out_resp != 2'd0) && busy_q[out_tag];
        spurious_hit = (out_resp != 2'd0) && !busy_q[out_tag];

        // A response on the expiry edge wins; only one tag times out per cycle,
        // any other expired tag stays saturated and is reported next cycle.
        to_hit = 1'b0;
        to_tag = '0;
        for (int i = NUM_TAGS - 1; i >= 0; i--) begin
            if (busy_q[i] && (age_q[i] == AGE_MAX) &&
                !(retire_hit && (out_tag == TAG_W'(i)))) begin
                to_hit = 1'b1;
                to_tag = TAG_W'(i);
            end
        end

        busy_d = busy_q;
        age_d  = age_q;
        for (int i = 0; i < NUM_TAGS; i++) begin
            if (busy_q[i] && (age_q[i] != AGE_MAX)) age_d[i] = age_q[i] + AGE_ONE;
        end
        if (retire_hit) busy_d[out_tag] = 1'b0;
        if (to_hit)     busy_d[to_tag]  = 1'b0;
        // Allocation looks at busy_q, so a tag freed this edge is never reused this edge.
        if (accept) begin
            busy_d[free_tag] = 1'b1;
            age_d[free_tag]  = '0;
        end

        state_d    = state_q;
        req_cmd_d  = 4'd0;
        req_data_d = '0;
        req_tag_d  = req_tag_q;
        op2_d      = op2_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_OP1;
                    req_cmd_d  = cmd_op;
                    req_data_d = cmd_op1;
                    req_tag_d  = free_tag;
                    op2_d      = cmd_op2;
                end
            end
            ST_OP1: begin
                state_d    = ST_OP2;
                req_data_d = op2_q;
            end
            ST_OP2: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        rsp_valid_d = retire_hit;
        rsp_resp_d  = retire_hit ? out_resp : rsp_resp_q;
        rsp_data_d  = retire_hit ? out_data : rsp_data_q;
        rsp_tag_d   = retire_hit ? out_tag  : rsp_tag_q;
        spurious_d  = spurious_hit;
        timeout_d   = to_hit;
        err_tag_d   = to_hit ? to_tag : (spurious_hit ? out_tag : err_tag_q);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            req_cmd_q   <= 4'd0;
            req_data_q  <= '0;
            req_tag_q   <= '0;
            op2_q       <= '0;
            busy_q      <= '0;
            for (int i = 0; i < NUM_TAGS; i++) age_q[i] <= '0;
            rsp_valid_q <= 1'b0;
            rsp_resp_q  <= 2'd0;
            rsp_data_q  <= '0;
            rsp_tag_q   <= '0;
            spurious_q  <= 1'b0;
            timeout_q   <= 1'b0;
            err_tag_q   <= '0;
        end else begin
            state_q     <= state_d;
            req_cmd_q   <= req_cmd_d;
            req_data_q  <= req_data_d;
            req_tag_q   <= req_tag_d;
            op2_q       <= op2_d;
            busy_q      <= busy_d;
            for (int i = 0; i < NUM_TAGS; i++) age_q[i] <= age_d[i];
            rsp_valid_q <= rsp_valid_d;
            rsp_resp_q  <= rsp_resp_d;
            rsp_data_q  <= rsp_data_d;
            rsp_tag_q   <= rsp_tag_d;
            spurious_q  <= spurious_d;
            timeout_q   <= timeout_d;
            err_tag_q   <= err_tag_d;
        end
    end

    assign req_cmd      = req_cmd_q;
    assign req_data     = req_data_q;
    assign req_tag      = req_tag_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_resp     = rsp_resp_q;
    assign rsp_data     = rsp_data_q;
    assign rsp_tag      = rsp_tag_q;
    assign spurious_err = spurious_q;
    assign timeout_err  = timeout_q;
    assign err_tag      = err_tag_q;
    assign busy_mask    = busy_q;

endmodule

// File: tb/tb_calc_req_driver.sv
// tb/tb_calc_req_driver.sv - self-checking bench for calc_req_driver
module tb_calc_req_driver;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [3:0]  cmd_op = 4'd0;
    logic [31:0] cmd_op1 = 32'd0;
    logic [31:0] cmd_op2 = 32'd0;
    logic [1:0]  out_resp = 2'd0;
    logic [31:0] out_data = 32'd0;
    logic [1:0]  out_tag = 2'd0;

    logic        cmd_ready, rsp_valid, spurious_err, timeout_err;
    logic [3:0]  req_cmd, busy_mask;
    logic [31:0] req_data, rsp_data;
    logic [1:0]  req_tag, rsp_resp, rsp_tag, err_tag;

    logic        to_cmd_ready, to_rsp_valid, to_spurious_err, to_timeout_err;
    logic [3:0]  to_req_cmd, to_busy_mask;
    logic [31:0] to_req_data, to_rsp_data;
    logic [1:0]  to_req_tag, to_rsp_resp, to_rsp_tag, to_err_tag;

    calc_req_driver #(.DATA_W(32), .NUM_TAGS(4), .TIMEOUT(64)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
        .req_cmd(req_cmd), .req_data(req_data), .req_tag(req_tag),
        .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
        .rsp_valid(rsp_valid), .rsp_resp(rsp_resp), .rsp_data(rsp_data), .rsp_tag(rsp_tag),
        .spurious_err(spurious_err), .timeout_err(timeout_err), .err_tag(err_tag),
        .busy_mask(busy_mask)
    );

    calc_req_driver #(.DATA_W(32), .NUM_TAGS(4), .TIMEOUT(8)) dut_to (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(to_cmd_ready),
        .cmd_op(cmd_op), .cmd_op1(cmd_op1), .cmd_op2(cmd_op2),
        .req_cmd(to_req_cmd), .req_data(to_req_data), .req_tag(to_req_tag),
        .out_resp(out_resp), .out_data(out_data), .out_tag(out_tag),
        .rsp_valid(to_rsp_valid), .rsp_resp(to_rsp_resp), .rsp_data(to_rsp_data),
        .rsp_tag(to_rsp_tag), .spurious_err(to_spurious_err), .timeout_err(to_timeout_err),
        .err_tag(to_err_tag), .busy_mask(to_busy_mask)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [1:0]  resp;
        logic [31:0] data;
        logic [1:0]  tag;
    } exp_rsp_t;
    exp_rsp_t sb_q[$];
    exp_rsp_t mon_e;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [1:0]  resp;
        logic [31:0] rdata;
    } vec_t;
    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL rsp_unexpected: got rsp_valid tag %0d required no response at %0t",
                         rsp_tag, $time);
            end else begin
                mon_e = sb_q.pop_front();
                check("rsp_resp", rsp_resp, mon_e.resp);
                check("rsp_data", rsp_data, mon_e.data);
                check("rsp_tag", rsp_tag, mon_e.tag);
            end
        end
    end

    task automatic accept_cmd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic got;
        got = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_op1   = a;
        cmd_op2   = b;
        for (int k = 0; k < 20 && !got; k++) begin
            #1;
            if (cmd_ready) begin
                @(posedge clk);
                got = 1'b1;
            end else begin
                @(negedge clk);
            end
        end
        #1 cmd_valid = 1'b0;
        check("accept_within_budget", got, 1'b1);
    endtask

    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [1:0] exp_tag);
        accept_cmd(op, a, b);
        @(negedge clk);
        check("op1_req_cmd", req_cmd, op);
        check("op1_req_data", req_data, a);
        check("op1_req_tag", req_tag, exp_tag);
        @(negedge clk);
        check("op2_req_cmd", req_cmd, 4'd0);
        check("op2_req_data", req_data, b);
        check("op2_req_tag", req_tag, exp_tag);
        @(negedge clk);
        check("idle_req", {req_cmd, req_data}, 36'd0);
    endtask

    task automatic respond(input logic [1:0] resp, input logic [31:0] data,
                           input logic [1:0] tag, input logic retire);
        exp_rsp_t e;
        @(negedge clk);
        out_resp = resp;
        out_data = data;
        out_tag  = tag;
        if (retire) begin
            e.resp = resp;
            e.data = data;
            e.tag  = tag;
            sb_q.push_back(e);
        end
        @(negedge clk);
        out_resp = 2'd0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[4];
        int cyc_seen;
        logic busy_pre;

        vecs[0] = '{4'd1,  32'd5,          32'd7,          2'd1, 32'd12};
        vecs[1] = '{4'd2,  32'd100,        32'd30,         2'd1, 32'd70};
        vecs[2] = '{4'd3,  32'hFFFF_FFFF,  32'd2,          2'd2, 32'hFFFF_FFFE};
        vecs[3] = '{4'd4,  32'd9,          32'd0,          2'd3, 32'd0};
        vecs[4] = '{4'd15, 32'hDEAD_BEEF,  32'h1234_5678,  2'd1, 32'hCAFE_F00D};
        order   = '{0, 1, 3, 2};

        // Reset held for three cycles with no command.
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ctrl", {req_cmd, req_tag, rsp_valid, rsp_resp, rsp_tag, spurious_err,
                             timeout_err, err_tag, busy_mask, cmd_ready}, 64'd0);
        check("reset_data", {req_data, rsp_data}, 64'd0);
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            issue(vecs[i].op, vecs[i].op1, vecs[i].op2, 2'd0);
            check("busy_after_issue", busy_mask, 4'b0001);
            respond(vecs[i].resp, vecs[i].rdata, 2'd0, 1'b1);
            check("busy_after_retire", busy_mask, 4'b0000);
        end

        // Opcode 0 is never accepted.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'd0;
        #1 check("op0_not_ready", cmd_ready, 1'b0);
        repeat (3) @(negedge clk);
        check("op0_no_issue", {req_cmd, busy_mask}, 8'd0);
        cmd_valid = 1'b0;

        for (int t = 0; t < 4; t++) issue(4'd1, 32'(t * 10), 32'(t), 2'(t));
        check("all_busy", busy_mask, 4'b1111);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = 4'd5;
        cmd_op1   = 32'h0000_0050;
        cmd_op2   = 32'h0000_0051;
        #1 check("full_not_ready", cmd_ready, 1'b0);
        repeat (3) begin
            @(negedge clk);
            check("full_held", req_cmd, 4'd0);
        end
        cmd_valid = 1'b0;
        respond(2'd1, 32'h0000_00A2, 2'd2, 1'b1);
        check("busy_after_tag2", busy_mask, 4'b1011);
        issue(4'd5, 32'h0000_0050, 32'h0000_0051, 2'd2);
        check("busy_refilled", busy_mask, 4'b1111);
        for (int t = 0; t < 4; t++) respond(2'd1, 32'(100 + order[t]), 2'(order[t]), 1'b1);
        check("busy_drained", busy_mask, 4'b0000);

        // Spurious response on a tag that is not outstanding.
        issue(4'd6, 32'd1, 32'd2, 2'd0);
        respond(2'd1, 32'h55, 2'd3, 1'b0);
        check("spurious_pulse", spurious_err, 1'b1);
        check("spurious_tag", err_tag, 2'd3);
        check("spurious_busy", busy_mask, 4'b0001);
        check("spurious_no_rsp", rsp_valid, 1'b0);
        @(negedge clk);
        check("spurious_one_cycle", spurious_err, 1'b0);
        respond(2'd1, 32'h77, 2'd0, 1'b1);

        // Reset during the OP2 cycle aborts the command.
        accept_cmd(4'd2, 32'h11, 32'h22);
        @(negedge clk);
        @(negedge clk);
        check("op2_before_reset", req_data, 32'h22);
        reset = 1'b1;
        @(negedge clk);
        check("reset_abort", {req_cmd, busy_mask, to_busy_mask, rsp_valid, cmd_ready}, 64'd0);
        check("reset_abort_data", req_data, 32'd0);
        reset = 1'b0;

        // Timeout on the TIMEOUT=8 instance: pulse 8 cycles after the issue cycle.
        accept_cmd(4'd1, 32'd3, 32'd4);
        cyc_seen = 0;
        busy_pre = 1'b0;
        for (int c = 1; c <= 20 && cyc_seen == 0; c++) begin
            @(negedge clk);
            if (c == 8) busy_pre = to_busy_mask[0];
            if (to_timeout_err) cyc_seen = c;
        end
        check("timeout_cycle", cyc_seen, 9);
        check("timeout_busy_before", busy_pre, 1'b1);
        check("timeout_err_tag", to_err_tag, 2'd0);
        check("timeout_busy_after", to_busy_mask, 4'b0000);
        @(negedge clk);
        check("timeout_one_cycle", to_timeout_err, 1'b0);
        respond(2'd1, 32'd7, 2'd0, 1'b1);

        // Response on the expiry edge retires normally, no timeout.
        accept_cmd(4'd1, 32'd8, 32'd9);
        for (int c = 1; c <= 8; c++) @(negedge clk);
        out_resp = 2'd1;
        out_data = 32'd17;
        out_tag  = 2'd0;
        sb_q.push_back('{2'd1, 32'd17, 2'd0});
        @(negedge clk);
        out_resp = 2'd0;
        check("race_rsp_valid", to_rsp_valid, 1'b1);
        check("race_rsp_data", to_rsp_data, 32'd17);
        check("race_no_timeout", to_timeout_err, 1'b0);
        check("race_busy", to_busy_mask, 4'b0000);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
